serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit pair per clock, LSB first.
// An accepted start loads the operands into shift registers; WIDTH RUN
// cycles later Sum/Carry update and done pulses for one cycle.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (b inverted on load, carry-in forced to 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Operand/carry-in as presented at the accepting edge.
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
    always_comb begin
        b_load   = sub ? ~b : b;
        cin_load = sub;
    end
`else
    // Plain addition: b as-is, carry-in 0.
    always_comb begin
        b_load   = b;
        cin_load = 1'b0;
    end
`endif

    // Full-adder bit of the current LSB pair and the shifted result word.
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_shifted;

    // One full-adder slice; sum bit enters the result from the MSB side.
    always_comb begin
        bit_s       = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c       = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        res_shifted = {bit_s, res_q[WIDTH-1:1]};
    end

    // Next-state logic: accept start outside RUN, step one bit per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = cin_load;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here.
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shifted;
                carry_d = bit_c;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_shifted;
                    cout_d  = bit_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status and results are decoded straight from registers.
    always_comb begin
        busy  = (state_q == ST_RUN);
        done  = (state_q == ST_DONE);
        Sum   = sum_q;
        Carry = cout_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus hand-written
// sequences for mid-run start, mid-run reset and back-to-back operation.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] Sum;
    logic       Carry;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif

    int total;
    int bad;
    int cyc;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // One full operation: accept, scramble a/b during RUN, wait for done.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] es, input logic ec, input string nm);
        int         busy_n;
        int         waited;
        logic [7:0] held;
        logic       held_ok;
        logic       overlap;
        held    = Sum;
        held_ok = 1'b1;
        overlap = 1'b0;
        busy_n  = 0;
        waited  = 0;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && waited < 20) begin
            if (busy) busy_n++;
            if (busy && done) overlap = 1'b1;
            if (Sum !== held) held_ok = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            waited++;
        end
        check({nm, " done seen"}, 32'(done), 32'd1);
        check({nm, " busy cycles"}, busy_n, 8);
        check({nm, " Sum"}, 32'(Sum), 32'(es));
        check({nm, " Carry"}, 32'(Carry), 32'(ec));
        check({nm, " Sum held during run"}, 32'(held_ok), 32'd1);
        check({nm, " busy&done overlap"}, 32'(overlap | (busy & done)), 32'd0);
        @(negedge clk);
        check({nm, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vecs[8];
        int   t1;
        int   t2;
        int   n_done;
        int   waited;
        logic [7:0] cap_sum;
        logic       cap_carry;

        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        vecs[0] = '{8'd3,   8'd5,   8'd8,   1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd0,   1'b1};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd254, 1'b1};
        vecs[4] = '{8'd128, 8'd128, 8'd0,   1'b1};
        vecs[5] = '{8'd170, 8'd85,  8'd255, 1'b0};
        vecs[6] = '{8'd1,   8'd1,   8'd2,   1'b0};
        vecs[7] = '{8'd200, 8'd100, 8'd44,  1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset Sum", 32'(Sum), 32'd0);
        check("reset Carry", 32'(Carry), 32'd0);
        rst_n = 1'b1;

        // Table-driven additions.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));
        end

        // Reset in the 4th RUN cycle; previous result 44/1 must clear at once.
        @(negedge clk);
        a = 8'd100; b = 8'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        check("async reset Sum", 32'(Sum), 32'd0);
        check("async reset Carry", 32'(Carry), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("no done after reset abort", n_done, 0);
        run_op(8'd7, 8'd9, 8'd16, 1'b0, "after reset");

        // start pulsed mid-RUN with 9+9 must be ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; cap_sum = 8'd0; cap_carry = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (done) begin
                n_done++;
                cap_sum = Sum;
                cap_carry = Carry;
            end
            @(negedge clk);
        end
        check("mid-run start done count", n_done, 1);
        check("mid-run start Sum", 32'(cap_sum), 32'd30);
        check("mid-run start Carry", 32'(cap_carry), 32'd0);

        // Back-to-back: start held through DONE with new operands.
        @(negedge clk);
        a = 8'd20; b = 8'd30; start = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        t1 = cyc;
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first Sum", 32'(Sum), 32'd50);
        a = 8'd40; b = 8'd50;
        @(negedge clk);
        start = 1'b0;
        check("b2b no idle bubble", 32'(busy), 32'd1);
        waited = 0;
        while (!done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        t2 = cyc;
        check("b2b second done", 32'(done), 32'd1);
        check("b2b done spacing", t2 - t1, 9);
        check("b2b second Sum", 32'(Sum), 32'd90);
        check("b2b second Carry", 32'(Carry), 32'd0);
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(8'd5, 8'd3, 8'd2, 1'b1, "sub 5-3");
        run_op(8'd3, 8'd5, 8'd254, 1'b0, "sub 3-5");
        sub = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
